// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative MULT/MULTU/DIV/DIVU sequencer owning the HI/LO write path.
// One shift-add / restoring-divide iteration per cycle for WIDTH cycles, then a
// single DONE cycle applies sign fix-up and strobes wen_hilo.
// Optional build macro: MULDIV_FAST_MUL_EN (multiplies skip BUSY and use a
// combinational multiplier on the latched magnitudes).
module muldiv_seq #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    output logic             busy,
    output logic             stall_req,
    output logic             wen_hilo,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_is_div;
    logic                 r_neg_q;     // negate product / quotient
    logic                 r_neg_r;     // negate remainder (dividend was negative)
    logic [WIDTH-1:0]     r_mag_a;     // multiplicand / dividend magnitude
    logic [WIDTH-1:0]     r_mag_b;     // multiplier / divisor magnitude
    logic [2*WIDTH-1:0]   r_acc;       // mul: {partial, multiplier}; div: {remainder, dividend/quotient}
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;

    logic                 w_accept;
    logic                 w_signed;
    logic                 w_is_div;
    logic                 w_div0;
    logic                 w_a_neg;
    logic                 w_b_neg;
    logic [WIDTH-1:0]     w_mag_a;
    logic [WIDTH-1:0]     w_mag_b;

    logic [WIDTH:0]       w_sum;
    logic [2*WIDTH-1:0]   w_mul_step;
    logic [WIDTH:0]       w_rem;
    logic [WIDTH:0]       w_diff;
    logic [2*WIDTH-1:0]   w_div_step;

    logic [2*WIDTH-1:0]   w_prod;
    logic [2*WIDTH-1:0]   w_prod_fix;
    logic [WIDTH-1:0]     w_q_fix;
    logic [WIDTH-1:0]     w_r_fix;
    logic [WIDTH-1:0]     w_res_hi;
    logic [WIDTH-1:0]     w_res_lo;

    // Operand decode and magnitude extraction at accept time.
    // A zero divisor clears both signs and keeps the raw dividend, so the plain
    // restoring loop yields remainder=src_a and quotient=all ones with no fix-up.
    assign w_accept = (r_state == S_IDLE) && start && !flush;
    assign w_signed = ~op[0];
    assign w_is_div = op[1];
    assign w_div0   = w_is_div && (src_b == '0);
    assign w_a_neg  = w_signed && src_a[WIDTH-1] && !w_div0;
    assign w_b_neg  = w_signed && src_b[WIDTH-1] && !w_div0;
    assign w_mag_a  = w_a_neg ? ('0 - src_a) : src_a;
    assign w_mag_b  = w_b_neg ? ('0 - src_b) : src_b;

    // One shift-add multiply iteration: add multiplicand on multiplier LSB, shift right.
    assign w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_mag_a};
    assign w_mul_step = r_acc[0] ? {w_sum, r_acc[WIDTH-1:1]}
                                 : {1'b0, r_acc[2*WIDTH-1:1]};

    // One restoring-divide iteration: shift dividend MSB into remainder, trial subtract.
    assign w_rem      = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_diff     = w_rem - {1'b0, r_mag_b};
    assign w_div_step = w_diff[WIDTH] ? {w_rem[WIDTH-1:0],  r_acc[WIDTH-2:0], 1'b0}
                                      : {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

`ifdef MULDIV_FAST_MUL_EN
    assign w_prod = r_is_div ? r_acc
                             : ({{WIDTH{1'b0}}, r_mag_a} * {{WIDTH{1'b0}}, r_mag_b});
`else
    assign w_prod = r_acc;
`endif

    // Sign fix-up applied in DONE.
    assign w_prod_fix = r_neg_q ? ('0 - w_prod) : w_prod;
    assign w_q_fix    = r_neg_q ? ('0 - r_acc[WIDTH-1:0]) : r_acc[WIDTH-1:0];
    assign w_r_fix    = r_neg_r ? ('0 - r_acc[2*WIDTH-1:WIDTH]) : r_acc[2*WIDTH-1:WIDTH];
    assign w_res_hi   = r_is_div ? w_r_fix : w_prod_fix[2*WIDTH-1:WIDTH];
    assign w_res_lo   = r_is_div ? w_q_fix : w_prod_fix[WIDTH-1:0];

    // hi/lo present the new result during the strobe cycle and hold it afterwards.
    assign hi = wen_hilo ? w_res_hi : r_hi;
    assign lo = wen_hilo ? w_res_lo : r_lo;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and control outputs.
    always_comb begin
        w_next    = r_state;
        busy      = 1'b0;
        stall_req = 1'b0;
        wen_hilo  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    stall_req = 1'b1;
                    w_next    = S_BUSY;
`ifdef MULDIV_FAST_MUL_EN
                    if (!op[1]) begin
                        w_next = S_DONE;
                    end
`endif
                end
            end
            S_BUSY: begin
                busy      = 1'b1;
                stall_req = 1'b1;
                if (flush) begin
                    w_next = S_IDLE;
                end else if (r_cnt == CNT_W'(1)) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                busy     = 1'b1;
                wen_hilo = !flush;
                w_next   = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Operand latch, iteration datapath and iteration counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_mag_a  <= '0;
            r_mag_b  <= '0;
            r_acc    <= '0;
        end else if (w_accept) begin
            r_cnt    <= CNT_W'(WIDTH);
            r_is_div <= w_is_div;
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_is_div && w_a_neg;
            r_mag_a  <= w_mag_a;
            r_mag_b  <= w_mag_b;
            r_acc    <= w_is_div ? {{WIDTH{1'b0}}, w_mag_a} : {{WIDTH{1'b0}}, w_mag_b};
        end else if (r_state == S_BUSY && !flush) begin
            r_cnt <= r_cnt - CNT_W'(1);
            r_acc <= r_is_div ? w_div_step : w_mul_step;
        end
    end

    // HI/LO result registers, written only on the strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (wen_hilo) begin
            r_hi <= w_res_hi;
            r_lo <= w_res_lo;
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed, table-driven bench for muldiv_seq plus hand-written flush/reset sequences.
module tb_muldiv_seq;

`ifdef MULDIV_FAST_MUL_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        busy;
    logic        stall_req;
    logic        wen_hilo;
    logic [31:0] hi;
    logic [31:0] lo;

    int total;
    int bad;

    muldiv_seq #(.WIDTH(32), .CNT_W(6)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .src_a     (src_a),
        .src_b     (src_b),
        .flush     (flush),
        .busy      (busy),
        .stall_req (stall_req),
        .wen_hilo  (wen_hilo),
        .hi        (hi),
        .lo        (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        bit          hold;
    } vec_t;

    task automatic check(input string nm, input logic [71:0] act, input logic [71:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Launch one operation at the current negedge and follow it to its strobe.
    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eh, input logic [31:0] el, input bit hold,
                         input string nm);
        int k;
        int lat;
        bit got;
        bit stall_ok;
        lat   = (FAST && !o[1]) ? 1 : 33;
        op    = o;
        src_a = a;
        src_b = b;
        start = 1'b1;
        #1;
        stall_ok = (stall_req === 1'b1) && (busy === 1'b0);
        k   = 0;
        got = 1'b0;
        while (!got && k < 100) begin
            @(negedge clk);
            k++;
            if (hold) begin
                op    = 2'($urandom);
                src_a = $urandom;
                src_b = $urandom;
            end else begin
                start = 1'b0;
            end
            #1;
            if (wen_hilo === 1'b1) begin
                got = 1'b1;
                if (stall_req !== 1'b0 || busy !== 1'b1) stall_ok = 1'b0;
            end else if (stall_req !== 1'b1 || busy !== 1'b1) begin
                stall_ok = 1'b0;
            end
        end
        start = 1'b0;
        check({nm, " stall"}, 72'(stall_ok), 72'(1));
        check({nm, " latency"}, 72'(k), 72'(lat));
        check({nm, " hi"}, 72'(hi), 72'(eh));
        check({nm, " lo"}, 72'(lo), 72'(el));
        @(negedge clk);
        #1;
        check({nm, " after"}, 72'({wen_hilo, busy, hi, lo}), 72'({1'b0, 1'b0, eh, el}));
    endtask

    initial begin
        vec_t        vecs[$];
        logic [31:0] ph;
        logic [31:0] pl;
        bit          quiet;
        int          k;

        total = 0;
        bad   = 0;
        rst   = 1'b1;
        start = 1'b0;
        flush = 1'b0;
        op    = 2'b00;
        src_a = '0;
        src_b = '0;

        vecs.push_back('{OP_MULTU, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, 1'b0});
        vecs.push_back('{OP_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0});
        vecs.push_back('{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0});
        vecs.push_back('{OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       1'b0});
        vecs.push_back('{OP_DIVU,  32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF, 1'b0});
        vecs.push_back('{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0});
        vecs.push_back('{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0});
        vecs.push_back('{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0});
        vecs.push_back('{OP_MULT,  32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 1'b0});
        vecs.push_back('{OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0});
        vecs.push_back('{OP_DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b0});
        vecs.push_back('{OP_DIVU,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, 1'b0});
        vecs.push_back('{OP_DIVU,  32'd5,        32'd10,       32'd5,        32'd0,        1'b0});
        vecs.push_back('{OP_MULT,  32'hFFFFFFFD, 32'hFFFFFFF9, 32'h00000000, 32'd21,       1'b1});
        vecs.push_back('{OP_DIVU,  32'd1000,     32'd33,       32'd10,       32'd30,       1'b1});

        // Reset state.
        @(negedge clk);
        @(negedge clk);
        #1;
        check("reset outputs", 72'({busy, stall_req, wen_hilo, hi, lo}), 72'(0));
        rst = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].hold,
                  $sformatf("vec%0d", i));
        end

        // Flush in BUSY at N+10: IDLE at N+11, no write, hi/lo kept; restart at N+12.
        ph    = hi;
        pl    = lo;
        op    = FAST ? OP_DIVU : OP_MULTU;
        src_a = 32'd5;
        src_b = 32'd6;
        start = 1'b1;
        quiet = 1'b1;
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            start = 1'b0;
            flush = (c == 10);
            #1;
            if (wen_hilo !== 1'b0) quiet = 1'b0;
        end
        check("flush busy no write", 72'(quiet), 72'(1));
        check("flush busy idle", 72'({busy, stall_req, hi, lo}), 72'({1'b0, 1'b0, ph, pl}));
        @(negedge clk);
        do_op(OP_MULTU, 32'd5, 32'd6, 32'd0, 32'd30, 1'b0, "restart");

        // start together with flush in IDLE is not accepted.
        op    = OP_DIVU;
        src_a = 32'd9;
        src_b = 32'd3;
        start = 1'b1;
        flush = 1'b1;
        #1;
        check("start+flush stall", 72'(stall_req), 72'(0));
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        #1;
        check("start+flush idle", 72'({busy, hi, lo}), 72'({1'b0, 32'd0, 32'd30}));

        // Reset at N+5 aborts the operation and clears outputs.
        @(negedge clk);
        op    = OP_DIVU;
        src_a = 32'd77;
        src_b = 32'd5;
        start = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid reset outputs", 72'({busy, stall_req, wen_hilo, hi, lo}), 72'(0));
        quiet = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            #1;
            if (wen_hilo !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
        end
        check("mid reset quiet", 72'(quiet), 72'(1));

        // Flush in DONE suppresses the write.
        op    = OP_DIVU;
        src_a = 32'd100;
        src_b = 32'd7;
        start = 1'b1;
        k     = 0;
        while (busy !== 1'b1 && k < 5) begin
            @(negedge clk);
            start = 1'b0;
            k++;
        end
        for (int c = k; c < 33; c++) begin
            @(negedge clk);
        end
        flush = 1'b1;
        #1;
        check("flush done strobe", 72'({busy, wen_hilo, hi, lo}), 72'({1'b1, 1'b0, 64'd0}));
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("flush done after", 72'({busy, wen_hilo, hi, lo}), 72'({1'b0, 1'b0, 64'd0}));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
